pal_device: RTL and testbench

PAL_DEVICE -- requirements
Module: pal_device

---
 rtl/pal_pkg.sv | 24 ++
 rtl/pal_term.sv | 24 ++
 rtl/pal_device.sv | 86 ++++++++
 tb/tb_pal_device.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
// Shared sizes, default fuse map and mode-register bit positions for the PAL.
package pal_pkg;

  localparam int unsigned NUM_IN        = 4;
  localparam int unsigned NUM_OUT       = 2;
  localparam int unsigned TERMS_PER_OUT = 4;
  localparam int unsigned FUSE_W        = 2 * NUM_IN;
  localparam int unsigned NUM_TERMS     = NUM_OUT * TERMS_PER_OUT;
  localparam int unsigned ADDR_W        = $clog2(NUM_TERMS);

  // Mode register: [1:0] registered-mode per output, [3:2] invert per output.
  localparam int unsigned MODE_W        = 2 * NUM_OUT;
  localparam int unsigned MODE_REG_LSB  = 0;
  localparam int unsigned MODE_INV_LSB  = NUM_OUT;

  typedef logic [FUSE_W-1:0] fuse_row_t;

  // Output 0 = (in0&in1)|(in2&in3); output 1 = in0 ^ in1.
  localparam fuse_row_t DEFAULT_FUSES [NUM_TERMS] = '{
    8'h05, 8'h50, 8'h00, 8'h00,
    8'h09, 8'h06, 8'h00, 8'h00
  };

endpackage : pal_pkg

// File: rtl/pal_term.sv
// One PAL product term: AND of the literals selected by its fuse row.
module pal_term
  import pal_pkg::*;
(
  input  logic [NUM_IN-1:0] in_i,
  input  logic [FUSE_W-1:0] fuse_i,
  output logic              term_o
);

  logic [NUM_IN-1:0] lit_ok;

  // A literal pair passes unless a connected polarity disagrees with the input;
  // connecting both polarities therefore always fails the pair.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_lit
    assign lit_ok[i] = (~fuse_i[2*i]   |  in_i[i]) &
                       (~fuse_i[2*i+1] | ~in_i[i]);
  end

  // An unprogrammed (all-clear) row is forced to 0 rather than the empty AND.
  always_comb begin
    term_o = (&lit_ok) & (|fuse_i);
  end

endmodule : pal_term

// File: rtl/pal_device.sv
// Small programmable array logic device: 8 fuse-programmable product terms,
// two OR outputs with optional inversion and optional output register.
module pal_device
  import pal_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IN-1:0]  inputs,
  output logic [NUM_OUT-1:0] outputs,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [FUSE_W-1:0]  cfg_data,
  input  logic               mode_we,
  input  logic [MODE_W-1:0]  mode_data
);

  fuse_row_t          fuse_q [NUM_TERMS];
  fuse_row_t          fuse_d [NUM_TERMS];
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [NUM_OUT-1:0] out_q, out_d;

  logic [NUM_TERMS-1:0] term;
  logic [NUM_OUT-1:0]   sum;
  logic [NUM_OUT-1:0]   pre;
  logic [NUM_OUT-1:0]   registered;
  logic [NUM_OUT-1:0]   invert;

  // Product-term array.
  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    pal_term u_term (
      .in_i   (inputs),
      .fuse_i (fuse_q[t]),
      .term_o (term[t])
    );
  end

  assign registered = mode_q[MODE_REG_LSB +: NUM_OUT];
  assign invert     = mode_q[MODE_INV_LSB +: NUM_OUT];

  // OR each output's terms, then apply optional inversion.
  always_comb begin
    sum = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      sum[o] = |term[o*TERMS_PER_OUT +: TERMS_PER_OUT];
    end
    pre = sum ^ invert;
  end

  // Next-state for fuse rows, mode register and output flops.
  always_comb begin
    for (int t = 0; t < NUM_TERMS; t++) begin
      fuse_d[t] = fuse_q[t];
    end
    mode_d = mode_q;
    out_d  = pre;
    if (cfg_we) begin
      fuse_d[cfg_addr] = cfg_data;
    end
    if (mode_we) begin
      mode_d = mode_data;
    end
  end

  // Configuration and output registers; reset restores the default map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TERMS; t++) begin
        fuse_q[t] <= DEFAULT_FUSES[t];
      end
      mode_q <= '0;
      out_q  <= '0;
    end else begin
      for (int t = 0; t < NUM_TERMS; t++) begin
        fuse_q[t] <= fuse_d[t];
      end
      mode_q <= mode_d;
      out_q  <= out_d;
    end
  end

  // Per-output select between combinational and registered path.
  always_comb begin
    outputs = (registered & out_q) | (~registered & pre);
  end

endmodule : pal_device

// File: tb/tb_pal_device.sv
// Directed testbench for pal_device.
module tb_pal_device;

  logic       clk;
  logic       rst;
  logic [3:0] inputs;
  logic [1:0] outputs;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       mode_we;
  logic [3:0] mode_data;

  int checks;
  int failures;

  pal_device dut (
    .clk       (clk),
    .rst       (rst),
    .inputs    (inputs),
    .outputs   (outputs),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .mode_we   (mode_we),
    .mode_data (mode_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic write_row(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
  endtask

  logic [3:0] vec_in  [8];
  logic [1:0] vec_out [8];

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    inputs    = 4'b0001;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    mode_we   = 1'b0;
    mode_data = '0;

    // While in reset, combinational outputs follow the default map.
    #12;
    check("reset_default_0001", outputs, 2'b10);
    check("reset_flops_zero", dut.out_q, 2'b00);

    @(negedge clk);
    rst = 1'b0;

    // Default map truth vectors.
    vec_in  = '{4'b0000, 4'b0001, 4'b0011, 4'b1111, 4'b0111, 4'b1011, 4'b1001, 4'b0110};
    vec_out = '{2'b00,   2'b10,   2'b01,   2'b01,   2'b01,   2'b01,   2'b10,   2'b10};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      inputs = vec_in[i];
      #1;
      check($sformatf("default_in%b", vec_in[i]), outputs, vec_out[i]);
    end

    // Reprogram output 0 as ~in0.
    write_row(3'd0, 8'h02);
    write_row(3'd1, 8'h00);
    inputs = 4'b0000;
    #1;
    check("prog_not_in0_0000", outputs, 2'b01);
    inputs = 4'b0001;
    #1;
    check("prog_not_in0_0001", outputs, 2'b10);

    // Contradictory term on output 1 never fires.
    write_row(3'd4, 8'h03);
    write_row(3'd5, 8'h00);
    for (int v = 0; v < 16; v++) begin
      inputs = 4'(v);
      #1;
      check($sformatf("contradict_in%0d", v), {1'b0, outputs[1]}, 2'b00);
    end

    // Back to default map via reset pulse.
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    inputs = 4'b0011;
    #1;
    check("after_pulse_0011", outputs, 2'b01);

    // Registered + inverted output 0: flop captured old pre (1) at mode edge.
    @(negedge clk);
    mode_we   = 1'b1;
    mode_data = 4'b0101;
    @(posedge clk);
    #1;
    mode_we = 1'b0;
    check("reg_inv_after_mode_edge", outputs, 2'b01);
    #3;
    check("reg_inv_holds_midcycle", outputs, 2'b01);
    @(posedge clk);
    #1;
    check("reg_inv_after_next_edge", outputs, 2'b00);

    // Non-default map with registered/inverted output 0, then async reset.
    @(negedge clk);
    inputs = 4'b0001;
    write_row(3'd0, 8'h02);
    write_row(3'd1, 8'h00);
    #1;
    check("nondefault_registered_0001", outputs, 2'b11);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_default_0001", outputs, 2'b10);
    check("async_reset_flops_zero", dut.out_q, 2'b00);

    // A write while reset is high must not stick.
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 3'd0;
    cfg_data = 8'h02;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    inputs = 4'b0000;
    #1;
    check("write_in_reset_ignored_0000", outputs, 2'b00);
    @(posedge clk);
    #1;
    check("write_in_reset_ignored_edge", outputs, 2'b00);
    inputs = 4'b0011;
    #1;
    check("write_in_reset_ignored_0011", outputs, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pal_device
